// File: rtl/axi_pkg.sv
// Shared AXI write-slave definitions: response codes, FSM state encoding, LFSR seed.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HAVE_AW = 2'd1,
        ST_HAVE_W  = 2'd2,
        ST_RESP    = 2'd3
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/axi_wr_slave_if.sv
// AXI-lite write channel bundle (AW, W, B) between a master and axi_wr_slave.
interface axi_wr_slave_if;
    import axi_pkg::*;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/wr_mem.sv
// Byte-enabled 32-bit word array with one synchronous write port and a combinational debug read port.
module wr_mem
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          ren,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we && wstrb[i]) begin
                mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ren) begin
            rdata = mem[ridx];
        end
    end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI-lite single-beat write slave: AW/W capture FSM, address decode, B response.
// Define AXI_WR_BACKPRESSURE_EN to add LFSR-driven pseudo-random ready stalls.
module axi_wr_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic           clk,
    input  logic           rst,
    axi_wr_slave_if.slave  bus,
    input  logic [31:0]    dbg_addr,
    output logic [31:0]    dbg_rdata
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    wr_state_t   state, state_nxt;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;

    logic        awready_fsm, wready_fsm, bp_stall;
    logic        aw_hs, w_hs, complete;
    logic [31:0] wr_addr, wr_data, wr_off, dbg_off;
    logic [3:0]  wr_strb;
    logic        wr_in_range, dbg_in_range;

`ifdef AXI_WR_BACKPRESSURE_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign bp_stall = lfsr[0];
`else
    assign bp_stall = 1'b0;
`endif

    always_comb begin
        awready_fsm = (state == ST_IDLE) || (state == ST_HAVE_W);
        wready_fsm  = (state == ST_IDLE) || (state == ST_HAVE_AW);
    end

    assign bus.awready = awready_fsm & ~bp_stall;
    assign bus.wready  = wready_fsm & ~bp_stall;
    assign bus.bvalid  = (state == ST_RESP);
    assign bus.bresp   = bresp_q;

    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs  = bus.wvalid & bus.wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_nxt = ST_RESP;
                    complete  = 1'b1;
                end else if (aw_hs) begin
                    state_nxt = ST_HAVE_AW;
                end else if (w_hs) begin
                    state_nxt = ST_HAVE_W;
                end
            end
            ST_HAVE_AW: begin
                if (w_hs) begin
                    state_nxt = ST_RESP;
                    complete  = 1'b1;
                end
            end
            ST_HAVE_W: begin
                if (aw_hs) begin
                    state_nxt = ST_RESP;
                    complete  = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The completing edge mixes latched and live channel values.
    always_comb begin
        wr_addr = (state == ST_HAVE_AW) ? aw_addr_q : bus.awaddr;
        wr_data = (state == ST_HAVE_W)  ? w_data_q  : bus.wdata;
        wr_strb = (state == ST_HAVE_W)  ? w_strb_q  : bus.wstrb;
        wr_off  = wr_addr - BASE_ADDR;
        dbg_off = dbg_addr - BASE_ADDR;
        // Unsigned wrap makes addresses below BASE_ADDR compare out of range.
        wr_in_range  = (wr_off < SPAN);
        dbg_in_range = (dbg_off < SPAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= bus.awaddr;
            end
            if (w_hs) begin
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            if (complete) begin
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    wr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (complete & wr_in_range & ~rst),
        .widx  (wr_off[AW+1:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .ren   (dbg_in_range),
        .ridx  (dbg_off[AW+1:2]),
        .rdata (dbg_rdata)
    );

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed corner cases plus random writes against a word-map model.
module tb_axi_wr_slave;
    import axi_pkg::*;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;

    axi_wr_slave_if bus ();

    axi_wr_slave #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] model [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        longint unsigned x, lo, hi;
        x  = longint'(a);
        lo = longint'(BASE);
        hi = lo + 4 * longint'(DEPTH);
        return (x >= lo && x < hi) ? 2'b00 : 2'b11;
    endfunction

    function automatic void model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int key;
        logic [31:0] w;
        if (exp_resp(a) == 2'b00) begin
            key = int'((a - BASE) >> 2);
            w = model.exists(key) ? model[key] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            end
            model[key] = w;
        end
    endfunction

    task automatic check_word(input string tag, input int idx);
        logic [31:0] v;
        @(negedge clk);
        dbg_addr = BASE + 32'(4 * idx);
        #1 v = dbg_rdata;
        chk(tag, v, model[idx]);
    endtask

    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly, input int w_dly,
                             input int b_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int c = 0;
        logic [1:0] r0;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        while (!(aw_done && w_done) && c < 200) begin
            @(negedge clk);
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.wvalid  = !w_done && (c >= w_dly);
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            c++;
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk({tag, "_hs_done"}, 32'(aw_done && w_done), 32'd1);
        chk({tag, "_bvalid_p1"}, 32'(bus.bvalid), 32'd1);
        r0 = bus.bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            chk({tag, "_bvalid_hold"}, 32'(bus.bvalid), 32'd1);
            chk({tag, "_bresp_hold"}, 32'(bus.bresp), 32'(r0));
            chk({tag, "_awready_resp"}, 32'(bus.awready), 32'd0);
            chk({tag, "_wready_resp"}, 32'(bus.wready), 32'd0);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk({tag, "_bvalid_drop"}, 32'(bus.bvalid), 32'd0);
`ifndef AXI_WR_BACKPRESSURE_EN
        chk({tag, "_awready_back"}, 32'(bus.awready), 32'd1);
        chk({tag, "_wready_back"}, 32'(bus.wready), 32'd1);
`endif
        resp = r0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] a, d, v;
        logic [3:0]  s;
        int          c;

        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.bready  = 1'b0;
        dbg_addr    = BASE;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
`ifndef AXI_WR_BACKPRESSURE_EN
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_wready", 32'(bus.wready), 32'd1);
`endif
        rst = 1'b0;

        // AW and W together
        axi_write("together", 32'h2000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
        model_apply(32'h2000_0010, 32'hDEADBEEF, 4'hF);
        chk("together_resp", 32'(r), 32'd0);
        check_word("together_word", 4);

        // W leads AW by three cycles, partial strobe
        axi_write("pre_fill", 32'h2000_0004, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
        model_apply(32'h2000_0004, 32'hFFFFFFFF, 4'hF);
        axi_write("w_first", 32'h2000_0004, 32'h11223344, 4'b0101, 3, 0, 0, r);
        model_apply(32'h2000_0004, 32'h11223344, 4'b0101);
        chk("w_first_resp", 32'(r), 32'd0);
        check_word("w_first_word", 1);
        chk("w_first_model", model[1], 32'hFF22FF44);

        // Out-of-range addresses; words they would alias must not change
        axi_write("fill0", BASE, 32'hA0A0A0A0, 4'hF, 0, 0, 0, r);
        model_apply(BASE, 32'hA0A0A0A0, 4'hF);
        axi_write("fill_last", BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A5A5A, 4'hF, 0, 0, 0, r);
        model_apply(BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A5A5A, 4'hF);
        axi_write("oob_lo", 32'h1FFF_FFFC, 32'hCAFEF00D, 4'hF, 0, 0, 0, r);
        chk("oob_lo_resp", 32'(r), 32'(exp_resp(32'h1FFF_FFFC)));
        model_apply(32'h1FFF_FFFC, 32'hCAFEF00D, 4'hF);
        axi_write("oob_hi", 32'h2000_1000, 32'hCAFEF00D, 4'hF, 1, 0, 0, r);
        chk("oob_hi_resp", 32'(r), 32'(exp_resp(32'h2000_1000)));
        model_apply(32'h2000_1000, 32'hCAFEF00D, 4'hF);
        check_word("oob_word0", 0);
        check_word("oob_word1", 1);
        check_word("oob_word4", 4);
        check_word("oob_wordlast", int'(DEPTH - 1));
        @(negedge clk);
        dbg_addr = 32'h2000_1000;
        #1 chk("dbg_oob_hi", dbg_rdata, 32'h0);
        dbg_addr = 32'h1FFF_FFFC;
        #1 chk("dbg_oob_lo", dbg_rdata, 32'h0);

        // Stalled B channel
        axi_write("bstall", BASE + 32'h20, 32'h12345678, 4'hF, 0, 0, 5, r);
        model_apply(BASE + 32'h20, 32'h12345678, 4'hF);
        chk("bstall_resp", 32'(r), 32'd0);
        check_word("bstall_word", 8);

        // Reset while holding only the address
        axi_write("pre_rst", BASE + 32'h8, 32'h0BADF00D, 4'hF, 0, 0, 0, r);
        model_apply(BASE + 32'h8, 32'h0BADF00D, 4'hF);
        bus.awaddr = BASE + 32'h8;
        bus.wdata  = 32'hFFFF0000;
        bus.wstrb  = 4'hF;
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            bus.awvalid = 1'b1;
            if (bus.awready) break;
            c++;
        end
        chk("rst_mid_aw_accepted", 32'(c < 200), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        chk("rst_mid_bvalid_pre", 32'(bus.bvalid), 32'd0);
`ifndef AXI_WR_BACKPRESSURE_EN
        chk("rst_mid_awready_have_aw", 32'(bus.awready), 32'd0);
        chk("rst_mid_wready_have_aw", 32'(bus.wready), 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_bvalid_in_rst", 32'(bus.bvalid), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_bvalid_after", 32'(bus.bvalid), 32'd0);
        check_word("rst_mid_word", 2);
        axi_write("post_rst", BASE + 32'h8, 32'h600DCAFE, 4'hF, 0, 1, 0, r);
        model_apply(BASE + 32'h8, 32'h600DCAFE, 4'hF);
        chk("post_rst_resp", 32'(r), 32'd0);
        check_word("post_rst_word", 2);

        // Random traffic over a 16-word window
        for (int i = 16; i < 32; i++) begin
            d = $urandom;
            axi_write("rinit", BASE + 32'(4 * i), d, 4'hF, 0, 0, 0, r);
            model_apply(BASE + 32'(4 * i), d, 4'hF);
        end
        for (int n = 0; n < 100; n++) begin
            a = BASE + 32'(4 * $urandom_range(16, 31)) + 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write("rnd", a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), r);
            model_apply(a, d, s);
            chk("rnd_resp", 32'(r), 32'(exp_resp(a)));
            check_word("rnd_word", int'((a - BASE) >> 2));
        end
        for (int i = 16; i < 32; i++) begin
            check_word("rnd_final", i);
        end
        @(negedge clk);
        dbg_addr = BASE + 32'h10;
        #1 v = dbg_rdata;
        chk("final_word4", v, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
